// File: rtl/echo_timer_pkg.sv
// echo_timer_defines: definitions shared by the transmit counter and the
// echo timer.
//   - TXC_COUNT_W  : cycle-count width of the transmit counter
//   - ECHO_COUNT_W : default echo timer count width (tracks TXC_COUNT_W)
//   - S_*          : 3-bit echo timer state encodings, echo_state_t enum
package echo_timer_defines;

  // Transmit counter defines
  localparam int TXC_COUNT_W = 16;

  // Echo timer defines
  localparam int ECHO_COUNT_W = TXC_COUNT_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BLANK  = 3'd1;
  localparam logic [2:0] S_LISTEN = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_BLANK  = S_BLANK,
    ST_LISTEN = S_LISTEN,
    ST_DONE   = S_DONE
  } echo_state_t;

endpackage

// File: rtl/echo_timer_debounce.sv
// echo_debounce: qualifies an echo after DEBOUNCE_LEN consecutive high
// samples while listening, and remembers the timer value at the first sample
// of the current run. Built only when ECHO_DEBOUNCE_EN is defined.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_listen        : FSM is in LISTEN; run is cleared whenever low
//   i_echo          : echo comparator sample
//   i_timer         : current measurement timer
//   o_qualify       : this sample completes a qualifying run (combinational)
//   o_first_timer   : timer value at the first sample of the current run
`ifdef ECHO_DEBOUNCE_EN
module echo_debounce
  import echo_timer_defines::*;
#(
  parameter int COUNT_W      = ECHO_COUNT_W,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_listen,
  input  logic               i_echo,
  input  logic [COUNT_W-1:0] i_timer,
  output logic               o_qualify,
  output logic [COUNT_W-1:0] o_first_timer
);

  // r_run counts highs seen before the current sample, so the strobe can fire
  // on the sample that completes the run (lets an echo win a timeout tie).
  localparam logic [3:0] LAST_RUN = 4'(DEBOUNCE_LEN - 1);

  logic [3:0]         r_run;
  logic [COUNT_W-1:0] r_first;

  assign o_qualify     = i_listen & i_echo & (r_run == LAST_RUN);
  // On the first sample of a run the latch is not yet loaded.
  assign o_first_timer = (r_run == 4'd0) ? i_timer : r_first;

  // Run counter and first-sample timer latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run   <= 4'd0;
      r_first <= {COUNT_W{1'b0}};
    end else if (i_listen && i_echo) begin
      if (r_run == 4'd0) begin
        r_first <= i_timer;
      end else begin
        r_first <= r_first;
      end
      if (r_run != LAST_RUN) begin
        r_run <= r_run + 4'd1;
      end else begin
        r_run <= r_run;
      end
    end else begin
      r_run <= 4'd0;
    end
  end

endmodule
`endif

// File: rtl/echo_timer.sv
// echo_timer: measures ultrasonic time of flight. A rising edge on arm starts
// a cycle timer; echoes are ignored for blank_cycles, then the first qualified
// echo (or the timeout) produces a held result until ack.
// Macro ECHO_DEBOUNCE_EN: when defined, an echo must be high for DEBOUNCE_LEN
// consecutive LISTEN samples (echo_debounce); otherwise one sample qualifies.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   arm             : pulse_sent level; rising edge starts a measurement
//   echo_in         : synchronous receive comparator output
//   blank_cycles    : echo blanking window after arm
//   timeout_cycles  : timer value at which listening gives up
//   ack             : consumer took the result (used in DONE only)
//   tof             : time of flight, all-ones on timeout
//   tof_valid       : result held and valid
//   timed_out       : held result is a timeout
//   busy            : measurement in progress (BLANK or LISTEN)
module echo_timer
  import echo_timer_defines::*;
#(
  parameter int COUNT_W      = ECHO_COUNT_W,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               echo_in,
  input  logic [COUNT_W-1:0] blank_cycles,
  input  logic [COUNT_W-1:0] timeout_cycles,
  input  logic               ack,
  output logic [COUNT_W-1:0] tof,
  output logic               tof_valid,
  output logic               timed_out,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] ALL_ONES = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] ONE      = {{(COUNT_W-1){1'b0}}, 1'b1};

  if (DEBOUNCE_LEN < 2 || DEBOUNCE_LEN > 15) begin : g_len_check
    $error("echo_timer: DEBOUNCE_LEN must be in 2..15");
  end

  echo_state_t        r_state;
  echo_state_t        w_state_next;
  logic [COUNT_W-1:0] r_timer;
  logic [COUNT_W-1:0] r_blank;
  logic [COUNT_W-1:0] r_timeout;
  logic [COUNT_W-1:0] r_tof;
  logic               r_tof_valid;
  logic               r_timed_out;
  logic               r_busy;
  logic               r_arm_prev;

  logic               w_arm_edge;
  logic               w_listen;
  logic               w_qualify;
  logic [COUNT_W-1:0] w_echo_tof;
  logic               w_start;
  logic               w_load_echo;
  logic               w_load_timeout;
  logic               w_ack_done;

  assign w_arm_edge = arm & ~r_arm_prev;
  assign w_listen   = (r_state == ST_LISTEN);

`ifdef ECHO_DEBOUNCE_EN
  echo_debounce #(
    .COUNT_W      (COUNT_W),
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .i_listen      (w_listen),
    .i_echo        (echo_in),
    .i_timer       (r_timer),
    .o_qualify     (w_qualify),
    .o_first_timer (w_echo_tof)
  );
`else
  assign w_qualify  = w_listen & echo_in;
  assign w_echo_tof = r_timer;
`endif

  // Next-state and load-strobe decode
  always_comb begin
    w_state_next   = r_state;
    w_start        = 1'b0;
    w_load_echo    = 1'b0;
    w_load_timeout = 1'b0;
    w_ack_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm_edge) begin
          w_start      = 1'b1;
          w_state_next = (blank_cycles == {COUNT_W{1'b0}}) ? ST_LISTEN : ST_BLANK;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (r_timer == r_blank) begin
          w_state_next = ST_LISTEN;
        end else begin
          w_state_next = ST_BLANK;
        end
      end
      ST_LISTEN: begin
        // >= also covers a timeout already behind the blanking window.
        if (w_qualify) begin
          w_load_echo  = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_timer >= r_timeout) begin
          w_load_timeout = 1'b1;
          w_state_next   = ST_DONE;
        end else begin
          w_state_next = ST_LISTEN;
        end
      end
      ST_DONE: begin
        if (ack) begin
          w_ack_done   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timer, captured limits, result and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= {COUNT_W{1'b0}};
      r_blank     <= {COUNT_W{1'b0}};
      r_timeout   <= {COUNT_W{1'b0}};
      r_tof       <= {COUNT_W{1'b0}};
      r_tof_valid <= 1'b0;
      r_timed_out <= 1'b0;
      r_busy      <= 1'b0;
      // High so an arm already high at reset release is not an edge.
      r_arm_prev  <= 1'b1;
    end else begin
      r_arm_prev <= arm;
      r_busy     <= (w_state_next == ST_BLANK) || (w_state_next == ST_LISTEN);

      if (w_start) begin
        r_timer   <= {COUNT_W{1'b0}};
        r_blank   <= blank_cycles;
        r_timeout <= timeout_cycles;
      end else if ((r_state == ST_BLANK || r_state == ST_LISTEN) && r_timer != ALL_ONES) begin
        r_timer <= r_timer + ONE;
      end else begin
        r_timer <= r_timer;
      end

      if (w_load_echo) begin
        r_tof       <= w_echo_tof;
        r_tof_valid <= 1'b1;
        r_timed_out <= 1'b0;
      end else if (w_load_timeout) begin
        r_tof       <= ALL_ONES;
        r_tof_valid <= 1'b1;
        r_timed_out <= 1'b1;
      end else if (w_ack_done) begin
        r_tof_valid <= 1'b0;
        r_timed_out <= 1'b0;
      end else begin
        r_tof_valid <= r_tof_valid;
      end
    end
  end

  assign tof       = r_tof;
  assign tof_valid = r_tof_valid;
  assign timed_out = r_timed_out;
  assign busy      = r_busy;

endmodule
